// File: rtl/uart_echo_pkg.sv
// Shared types, default constants and the sample filter for the UART echo block.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        WAIT_HEADER = 2'd0,
        WAIT_DATA   = 2'd1,
        SEND        = 2'd2
    } state_t;

    localparam logic [7:0]  DEFAULT_HEADER_BYTE  = 8'hAA;
    localparam logic [7:0]  DEFAULT_CLIP_LEVEL   = 8'd200;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Button A clips to the ceiling and wins over button B, which halves the sample.
    function automatic logic [7:0] filter_sample(input logic [7:0] sample,
                                                 input logic       btn_a,
                                                 input logic       btn_b,
                                                 input logic [7:0] clip);
        logic [7:0] res;
        if (btn_a) begin
            res = (sample > clip) ? clip : sample;
        end else if (btn_b) begin
            res = {1'b0, sample[7:1]};
        end else begin
            res = sample;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, centre sampling; rx_dv_o pulses one clock per good byte.
module uart_rx_core import uart_echo_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       rx_dv_o,
    output logic [7:0] rx_byte_o
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       st_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            rx_dv_q;
    logic [7:0]      rx_byte_q;

    // Frame FSM: start re-check at half bit, then one sample per bit centre.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= RxIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_dv_q   <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            rx_dv_q <= 1'b0;
            unique case (st_q)
                RxIdle: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_i) st_q <= RxStart;
                end
                RxStart: begin
                    if (cnt_q == HalfBit) begin
                        cnt_q <= '0;
                        st_q  <= rx_i ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt_q == FullBit) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_i, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) st_q <= RxStop;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt_q == FullBit) begin
                        cnt_q <= '0;
                        st_q  <= RxIdle;
                        // Low stop bit is a framing error: drop the byte silently.
                        if (rx_i) begin
                            rx_dv_q   <= 1'b1;
                            rx_byte_q <= shift_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: st_q <= RxIdle;
            endcase
        end
    end

    assign rx_dv_o   = rx_dv_q;
    assign rx_byte_o = rx_byte_q;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter, LSB first; requests arriving while busy are ignored.
module uart_tx_core import uart_echo_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_dv_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_active_o,
    output logic       tx_o
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] FullBit = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e       st_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            active_q;
    logic            tx_q;

    // Frame FSM with registered line output; active stays high through the stop bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q      <= TxIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            active_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            unique case (st_q)
                TxIdle: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (tx_dv_i) begin
                        shift_q  <= tx_byte_i;
                        tx_q     <= 1'b0;
                        active_q <= 1'b1;
                        st_q     <= TxStart;
                    end
                end
                TxStart: begin
                    if (cnt_q == FullBit) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        st_q      <= TxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (cnt_q == FullBit) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q <= 1'b1;
                            st_q <= TxStop;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (cnt_q == FullBit) begin
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                        st_q     <= TxIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: st_q <= TxIdle;
            endcase
        end
    end

    assign tx_active_o = active_q;
    assign tx_o        = tx_q;

endmodule

// File: rtl/uart_echo_colorlight_i9.sv
// Colorlight i9 top: receives header+sample frames, filters the sample, echoes it back.
module uart_echo_colorlight_i9 import uart_echo_pkg::*; #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE,
    parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE,
    parameter logic [7:0]  CLIP_LEVEL   = DEFAULT_CLIP_LEVEL,
    parameter int unsigned RST_CYCLES   = 256
) (
    input  logic clk_50mhz,
    input  logic reset_n,
    input  logic uart_rx,
    output logic uart_tx,
    input  logic botao_a,
    input  logic botao_b
);
    localparam int unsigned RstW = $clog2(RST_CYCLES + 1);

    logic [RstW-1:0] rst_cnt_q;
    logic            core_rst_n_q;
    logic [1:0]      rx_sync_q;
    logic [1:0]      a_sync_q;
    logic [1:0]      b_sync_q;

    state_t     state_q;
    logic       tx_dv_q;
    logic [7:0] tx_byte_q;

    // Names kept at top level for monitoring.
    state_t     state;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;

    // Reset stretcher: asserts with reset_n, releases synchronously RST_CYCLES clocks later.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt_q    <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            if (rst_cnt_q != RstW'(RST_CYCLES)) rst_cnt_q <= rst_cnt_q + 1'b1;
            core_rst_n_q <= (rst_cnt_q == RstW'(RST_CYCLES));
        end
    end

    // Two-flop synchronisers for the asynchronous inputs; RX idles high.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q <= 2'b11;
            a_sync_q  <= 2'b00;
            b_sync_q  <= 2'b00;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx};
            a_sync_q  <= {a_sync_q[0], botao_a};
            b_sync_q  <= {b_sync_q[0], botao_b};
        end
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i    (clk_50mhz),
        .rst_ni   (core_rst_n_q),
        .rx_i     (rx_sync_q[1]),
        .rx_dv_o  (rx_dv),
        .rx_byte_o(rx_byte)
    );

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i      (clk_50mhz),
        .rst_ni     (core_rst_n_q),
        .tx_dv_i    (tx_dv),
        .tx_byte_i  (tx_byte),
        .tx_active_o(tx_active),
        .tx_o       (uart_tx)
    );

    // Frame FSM: header, then sample (filtered and latched), then one echo request.
    always_ff @(posedge clk_50mhz or negedge core_rst_n_q) begin
        if (!core_rst_n_q) begin
            state_q   <= WAIT_HEADER;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            unique case (state_q)
                WAIT_HEADER: begin
                    if (rx_dv && (rx_byte == HEADER_BYTE)) state_q <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (rx_dv) begin
                        tx_byte_q <= filter_sample(rx_byte, a_sync_q[1], b_sync_q[1], CLIP_LEVEL);
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_active) begin
                        tx_dv_q <= 1'b1;
                        state_q <= WAIT_HEADER;
                    end
                end
                default: state_q <= WAIT_HEADER;
            endcase
        end
    end

    assign state   = state_q;
    assign tx_dv   = tx_dv_q;
    assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_echo_colorlight_i9.sv
// Directed bench: drives framed bytes into uart_rx and decodes uart_tx independently.
module tb_uart_echo_colorlight_i9;
    import uart_echo_pkg::*;

    localparam int unsigned CPB     = 16;
    localparam int unsigned RST_CYC = 256;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic botao_a = 1'b0;
    logic botao_b = 1'b0;

    always #5 clk = ~clk;

    uart_echo_colorlight_i9 #(
        .CLK_FREQ    (1_843_200),
        .BAUD_RATE   (115_200),
        .CLKS_PER_BIT(CPB),
        .RST_CYCLES  (RST_CYC)
    ) dut (
        .clk_50mhz(clk),
        .reset_n  (reset_n),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .botao_a  (botao_a),
        .botao_b  (botao_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         byte_idx = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] dec_b;
    int         lat;
    int         found;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent line decoder: samples uart_tx at bit centres.
    initial begin
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                dec_b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            got_q.push_back(dec_b);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] sample, input logic [7:0] expected);
        send_byte(8'hAA, 1'b1);
        send_byte(sample, 1'b1);
        exp_q.push_back(expected);
    endtask

    task automatic flush_check(input string name);
        int n;
        repeat (24 * CPB) @(negedge clk);
        check_eq({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_byte%0d", name, byte_idx), got_q[i], exp_q[i]);
            byte_idx++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (4) @(negedge clk);
        check_eq("rst_uart_tx", uart_tx, 1);
        check_eq("rst_state", dut.state, WAIT_HEADER);
        check_eq("rst_tx_active", dut.tx_active, 0);
        reset_n = 1'b1;
        repeat (RST_CYC + 44) @(negedge clk);

        // Plain echo, back to back; headers must not be echoed.
        for (int i = 0; i < 5; i++) send_frame(8'hFA, 8'hFA);
        flush_check("plain_fa");

        botao_a = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) send_frame(8'hFA, 8'hC8);
        flush_check("clip_fa");

        botao_a = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h64, 8'd100);
        send_frame(8'h96, 8'd150);
        send_frame(8'hC8, 8'd200);
        send_frame(8'hFF, 8'd255);
        flush_check("plain_mix");

        // Clip boundary sweep: byte indices 12..20.
        botao_a = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'd50, 8'd50);
        send_frame(8'd100, 8'd100);
        send_frame(8'd150, 8'd150);
        send_frame(8'd199, 8'd199);
        send_frame(8'd200, 8'd200);
        send_frame(8'd201, 8'd200);
        send_frame(8'd220, 8'd200);
        send_frame(8'd240, 8'd200);
        send_frame(8'd255, 8'd200);
        flush_check("clip_sweep");

        botao_a = 1'b0;
        botao_b = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hF0, 8'h78);
        flush_check("atten");

        botao_a = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hF0, 8'hC8);
        flush_check("both");

        // Latency from sample rx_dv to start bit.
        botao_a = 1'b0;
        botao_b = 1'b0;
        repeat (4) @(negedge clk);
        fork
            send_frame(8'h3C, 8'h3C);
            begin
                found = 0;
                for (int i = 0; i < 40 * CPB && found == 0; i++) begin
                    @(negedge clk);
                    if (dut.rx_dv && dut.state == WAIT_DATA) found = 1;
                end
                check_eq("lat_rxdv_seen", found, 1);
                lat = 0;
                while (found == 1 && uart_tx == 1'b1 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                check_eq("lat_le3", (lat >= 1 && lat <= 3), 1);
            end
        join
        flush_check("lat");

        // Stray byte, then a header with a bad stop bit, then a valid frame.
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        check_eq("bad_hdr_state", dut.state, WAIT_HEADER);
        send_frame(8'h44, 8'h44);
        flush_check("stray_bad");

        // Reset in the middle of a transmitted byte.
        send_frame(8'h11, 8'h11);
        found = 0;
        for (int i = 0; i < 4 * CPB && found == 0; i++) begin
            if (uart_tx == 1'b0) found = 1;
            else @(negedge clk);
        end
        check_eq("midtx_started", found, 1);
        repeat (3 * CPB) @(negedge clk);
        check_eq("midtx_line_low", uart_tx, 0);
        reset_n = 1'b0;
        #1;
        check_eq("midtx_rst_tx_high", uart_tx, 1);
        check_eq("midtx_rst_state", dut.state, WAIT_HEADER);
        check_eq("midtx_rst_active", dut.tx_active, 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (RST_CYC + 44) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        send_frame(8'h5A, 8'h5A);
        flush_check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
